// File: rtl/pipe_ctrl_n.sv
// N-stage pipeline valid/handshake controller with cancel-flush, global freeze and saturating perf counters.
// Entries move one stage per edge; allow_in back-pressure ripples combinationally from writeback toward fetch.
module pipe_ctrl_n #(
    parameter int STAGES       = 5,
    parameter int FLUSH_STAGES = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_en,
    input  logic              freeze,
    input  logic [STAGES-1:0] stage_over,
    input  logic              cancel,
    input  logic              cnt_clr,
    output logic [STAGES-1:0] stage_valid,
    output logic [STAGES-1:0] allow_in,
    output logic [STAGES-2:0] advance,
    output logic              next_fetch,
    output logic              retire,
    output logic [31:0]       valid_vec,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] allow_w;
    logic [STAGES-1:0] leave_w;   // entry leaves stage i this edge; top bit is retire
    logic [STAGES-1:0] enter_w;   // entry arrives in stage i this edge
    logic              fetch_w;
    logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
    logic [CNT_W-1:0]  bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0]  fl_cnt_q, fl_cnt_d;

    always_comb begin : allow_chain
        logic chain;
        chain   = 1'b1;
        allow_w = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain      = !valid_q[i] | (stage_over[i] & chain);
            allow_w[i] = chain;
        end
    end

    always_comb begin
        leave_w = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            leave_w[i] = valid_q[i] & stage_over[i] & allow_w[i+1] & !freeze
                         & !(cancel && (i < FLUSH_STAGES));
        end
        leave_w[STAGES-1] = valid_q[STAGES-1] & stage_over[STAGES-1] & !freeze;
    end

    assign fetch_w = fetch_en & allow_w[0] & !freeze & !cancel;
    assign enter_w = {leave_w[STAGES-2:0], fetch_w};

    // Cancel beats freeze for the flushed prefix; a stage that both gains and loses keeps the new entry.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            if (cancel && (i < FLUSH_STAGES)) begin
                valid_d[i] = 1'b0;
            end else if (freeze) begin
                valid_d[i] = valid_q[i];
            end else if (enter_w[i]) begin
                valid_d[i] = 1'b1;
            end else if (leave_w[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        bub_cnt_d = bub_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        if (cnt_clr) begin
            ret_cnt_d = '0;
            bub_cnt_d = '0;
            fl_cnt_d  = '0;
        end else begin
            if (leave_w[STAGES-1] && (ret_cnt_q != CNT_MAX)) ret_cnt_d = ret_cnt_q + CNT_ONE;
            if (!freeze && !leave_w[STAGES-1] && (bub_cnt_q != CNT_MAX)) bub_cnt_d = bub_cnt_q + CNT_ONE;
            if (cancel && (fl_cnt_q != CNT_MAX)) fl_cnt_d = fl_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q   <= '0;
            ret_cnt_q <= '0;
            bub_cnt_q <= '0;
            fl_cnt_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            ret_cnt_q <= ret_cnt_d;
            bub_cnt_q <= bub_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign allow_in    = allow_w;
    assign advance     = leave_w[STAGES-2:0];
    assign retire      = leave_w[STAGES-1];
    assign next_fetch  = fetch_w;
    assign valid_vec   = {{(32-STAGES){1'b0}}, valid_q};
    assign retire_cnt  = ret_cnt_q;
    assign bubble_cnt  = bub_cnt_q;
    assign flush_cnt   = fl_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: retire-time scoreboard on three pipeline depths, plus freeze/saturation/reset on a 5-stage 8-bit-counter copy.
module tb_pipe_ctrl_n;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Depth sweep: fill/stream, mid-pipe stall, cancel, drain.
    for (genvar g = 0; g < 3; g++) begin : gen_cfg
        localparam int S  = (g == 0) ? 5 : (g == 1) ? 2 : 16;
        localparam int FL = (g == 0) ? 4 : (g == 1) ? 1 : 12;
        localparam int M  = (S > 3) ? 2 : S - 1;
        localparam logic [31:0] ONES = (32'd1 << S) - 32'd1;

        logic          rstn, fen, frz, cnl, clr;
        logic [S-1:0]  ovr, sv, ai;
        logic [S-2:0]  adv;
        logic          nf, ret;
        logic [31:0]   vv;
        logic [15:0]   rc, bc, fc;
        bit            done_g = 1'b0;
        int            cyc;
        int            exp_q[$];
        logic [S-1:0]  e;

        pipe_ctrl_n #(.STAGES(S), .FLUSH_STAGES(FL), .CNT_W(16)) dut (
            .clk(clk), .resetn(rstn), .fetch_en(fen), .freeze(frz), .stage_over(ovr),
            .cancel(cnl), .cnt_clr(clr), .stage_valid(sv), .allow_in(ai), .advance(adv),
            .next_fetch(nf), .retire(ret), .valid_vec(vv), .retire_cnt(rc),
            .bubble_cnt(bc), .flush_cnt(fc)
        );

        task automatic tick(input logic exp_nf);
            logic exp_ret;
            @(negedge clk);
            chk($sformatf("S%0d_next_fetch_c%0d", S, cyc), 32'(nf), 32'(exp_nf));
            if (exp_nf) exp_q.push_back(cyc + S);
            exp_ret = (exp_q.size() > 0) && (exp_q[0] == cyc);
            chk($sformatf("S%0d_retire_c%0d", S, cyc), 32'(ret), 32'(exp_ret));
            if (exp_ret) void'(exp_q.pop_front());
            @(posedge clk);
            #1;
            cyc++;
        endtask

        initial begin
            rstn = 1'b0; fen = 1'b0; frz = 1'b0; cnl = 1'b0; clr = 1'b0; ovr = '1; cyc = 0;
            @(negedge clk);
            chk($sformatf("S%0d_rst_valid", S), 32'(sv), 32'd0);
            chk($sformatf("S%0d_rst_allow", S), 32'(ai), ONES);
            chk($sformatf("S%0d_rst_adv", S), 32'(adv), 32'd0);
            chk($sformatf("S%0d_rst_retire", S), 32'(ret), 32'd0);
            chk($sformatf("S%0d_rst_cnt", S), {rc, bc | fc}, 32'd0);
            @(posedge clk);
            #1;
            rstn = 1'b1;
            fen  = 1'b1;

            // Streaming: first retire S cycles after the first fetch, so S bubbles.
            for (int i = 0; i < 20; i++) tick(1'b1);
            chk($sformatf("S%0d_t1_retire_cnt", S), 32'(rc), 32'(20 - S));
            chk($sformatf("S%0d_t1_bubble_cnt", S), 32'(bc), 32'(S));
            chk($sformatf("S%0d_t1_flush_cnt", S), 32'(fc), 32'd0);
            chk($sformatf("S%0d_t1_valid_vec", S), vv, ONES);

            // Stall stage M for 3 cycles: stages 0..M hold, so their entries retire 3 cycles late.
            for (int j = 0; j <= M; j++) exp_q[exp_q.size()-1-j] = exp_q[exp_q.size()-1-j] + 3;
            ovr[M] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                #2;
                chk($sformatf("S%0d_t2_adv_low_k%0d", S, k), 32'(adv[M-1:0]), 32'd0);
                tick(1'b0);
            end
            ovr = '1;
            e = '1;
            for (int j = M + 1; j <= M + 3; j++) if (j < S) e[j] = 1'b0;
            chk($sformatf("S%0d_t2_valid_after_stall", S), 32'(sv), 32'(e));
            for (int i = 0; i < S + 4; i++) tick(1'b1);

            // Cancel on a full pipe: the FL youngest entries never retire.
            for (int j = 0; j < FL; j++) void'(exp_q.pop_back());
            cnl = 1'b1;
            #2;
            chk($sformatf("S%0d_t3_adv_blocked", S), 32'(adv[FL-1:0]), 32'd0);
            tick(1'b0);
            cnl = 1'b0;
            e = '0;
            for (int j = FL + 1; j < S; j++) e[j] = 1'b1;
            chk($sformatf("S%0d_t3_valid_after_cancel", S), 32'(sv), 32'(e));
            chk($sformatf("S%0d_t3_flush_cnt", S), 32'(fc), 32'd1);
            for (int i = 0; i < S + 2; i++) tick(1'b1);
            fen = 1'b0;
            for (int i = 0; i < S + 2; i++) tick(1'b0);
            chk($sformatf("S%0d_sb_drained", S), 32'(exp_q.size()), 32'd0);
            done_g = 1'b1;
        end
    end

    // Freeze, freeze+cancel, counter saturation/clear, async reset: 5 stages, 8-bit counters.
    logic       rst5, fen5, frz5, cnl5, clr5;
    logic [4:0] ovr5, sv5, ai5;
    logic [3:0] adv5;
    logic       nf5, ret5;
    logic [31:0] vv5;
    logic [7:0] rc5, bc5, fc5;
    bit         done5 = 1'b0;

    pipe_ctrl_n #(.STAGES(5), .FLUSH_STAGES(4), .CNT_W(8)) dut5 (
        .clk(clk), .resetn(rst5), .fetch_en(fen5), .freeze(frz5), .stage_over(ovr5),
        .cancel(cnl5), .cnt_clr(clr5), .stage_valid(sv5), .allow_in(ai5), .advance(adv5),
        .next_fetch(nf5), .retire(ret5), .valid_vec(vv5), .retire_cnt(rc5),
        .bubble_cnt(bc5), .flush_cnt(fc5)
    );

    task automatic step5();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst5 = 1'b0; fen5 = 1'b0; frz5 = 1'b0; cnl5 = 1'b0; clr5 = 1'b0; ovr5 = '1;
        step5();
        rst5 = 1'b1;
        fen5 = 1'b1;
        repeat (8) step5();
        chk("W8_fill_valid", 32'(sv5), 32'h1F);
        chk("W8_fill_retire_cnt", 32'(rc5), 32'd3);
        chk("W8_fill_bubble_cnt", 32'(bc5), 32'd5);

        frz5 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("W8_frz_adv_k%0d", k), 32'(adv5), 32'd0);
            chk($sformatf("W8_frz_retire_k%0d", k), 32'(ret5), 32'd0);
            chk($sformatf("W8_frz_fetch_k%0d", k), 32'(nf5), 32'd0);
            step5();
        end
        chk("W8_frz_valid_held", 32'(sv5), 32'h1F);
        chk("W8_frz_bubble_held", 32'(bc5), 32'd5);
        chk("W8_frz_retire_held", 32'(rc5), 32'd3);

        cnl5 = 1'b1;
        step5();
        frz5 = 1'b0;
        cnl5 = 1'b0;
        chk("W8_frz_cancel_valid", 32'(sv5), 32'h10);
        chk("W8_frz_cancel_flush_cnt", 32'(fc5), 32'd1);
        chk("W8_frz_cancel_bubble", 32'(bc5), 32'd5);

        repeat (300) step5();
        chk("W8_retire_saturated", 32'(rc5), 32'hFF);
        clr5 = 1'b1;
        #2;
        chk("W8_clr_cycle_retire", 32'(ret5), 32'd1);
        step5();
        clr5 = 1'b0;
        chk("W8_clr_retire_cnt", 32'(rc5), 32'd0);
        chk("W8_clr_other_cnts", {16'd0, bc5, fc5}, 32'd0);
        step5();
        chk("W8_count_after_clr", 32'(rc5), 32'd1);

        #3;
        rst5 = 1'b0;
        #1;
        chk("W8_async_rst_valid", 32'(sv5), 32'd0);
        chk("W8_async_rst_cnt", {8'd0, rc5, bc5, fc5}, 32'd0);
        chk("W8_async_rst_allow", 32'(ai5), 32'h1F);
        step5();
        rst5 = 1'b1;
        #2;
        chk("W8_post_rst_fetch", 32'(nf5), 32'd1);
        step5();
        chk("W8_post_rst_valid", 32'(sv5), 32'd1);
        chk("W8_post_rst_bubble", 32'(bc5), 32'd1);
        done5 = 1'b1;
    end

    initial begin
        for (int t = 0; t < 30000; t++) begin
            if (gen_cfg[0].done_g && gen_cfg[1].done_g && gen_cfg[2].done_g && done5) break;
            @(posedge clk);
        end
        chk("all_tests_done",
            {28'd0, done5, gen_cfg[2].done_g, gen_cfg[1].done_g, gen_cfg[0].done_g}, 32'hF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
